// File: rtl/datapath_pkg.sv
// Shared constants and elaboration helpers for the datapath adder library.
package datapath_pkg;

  // Mode encoding for the add/subtract select input.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // True when WIDTH splits evenly into STAGES chunks of at least one bit.
  function automatic bit width_ok(input int w, input int s);
    return (s >= 1) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple adder built from full-adder cells.
// Exposes the carry into the MSB so the caller can form signed overflow.
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  input  logic          i_c,
  output logic [CW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_cmsb
);

  logic [CW:0] w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
  end

  assign o_cout = w_c[CW];
  assign o_cmsb = w_c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit. Each stage adds one CW-bit chunk and
// registers the chunk carry; unconsumed operand bits ride along and shrink as
// they go. Valid/ready handshake with full backpressure and bubble collapse.
module pipelined_adder
  import datapath_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0] w_vld;   // stage holds a beat
  logic [STAGES-1:0] w_en;    // stage may load this cycle (empty or draining)
  logic [WIDTH-1:0]  w_bp;    // B after optional inversion
  logic              w_c0;    // carry into bit 0
  logic              w_take;  // input handshake fires

  assign w_bp   = (sub == SUB) ? ~b : b;
  assign w_c0   = (sub == SUB) ? 1'b1 : cin;
  assign in_ready = w_en[0] && !rst;
  assign w_take = in_valid && in_ready;

  // Load enables ripple back from the output: a stage can take a new beat if it
  // is empty or its current beat moves on this cycle.
  always_comb begin
    w_en = '0;
    w_en[STAGES-1] = !w_vld[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_en[k] = !w_vld[k] || w_en[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  r_vld;
    logic [(k+1)*CW-1:0]   r_sum;   // low sum bits resolved so far
    logic                  r_c;     // carry out of this chunk
    logic [CW-1:0]         w_ca, w_cb, w_csum;
    logic [(k+1)*CW-1:0]   w_nsum;
    logic                  w_cin, w_cout, w_cmsb, w_nvld, w_load;

    if (k == 0) begin : g_src
      assign w_ca   = a[CW-1:0];
      assign w_cb   = w_bp[CW-1:0];
      assign w_cin  = w_c0;
      assign w_nvld = w_take;
      assign w_nsum = w_csum;
    end else begin : g_src
      assign w_ca   = g_stage[k-1].g_ops.r_a[k*CW +: CW];
      assign w_cb   = g_stage[k-1].g_ops.r_b[k*CW +: CW];
      assign w_cin  = g_stage[k-1].r_c;
      assign w_nvld = g_stage[k-1].r_vld;
      assign w_nsum = {w_csum, g_stage[k-1].r_sum};
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .i_a    (w_ca),
      .i_b    (w_cb),
      .i_c    (w_cin),
      .o_sum  (w_csum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
    );

    assign w_load   = w_en[k] && w_nvld;
    assign w_vld[k] = r_vld;

    // Stage valid, partial sum and chunk carry; data only moves with a real beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_sum <= '0;
        r_c   <= 1'b0;
      end else begin
        if (w_en[k]) r_vld <= w_nvld;
        if (w_load) begin
          r_sum <= w_nsum;
          r_c   <= w_cout;
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:(k+1)*CW] r_a, r_b, w_ua, w_ub;

      if (k == 0) begin : g_up
        assign w_ua = a[WIDTH-1:CW];
        assign w_ub = w_bp[WIDTH-1:CW];
      end else begin : g_up
        assign w_ua = g_stage[k-1].g_ops.r_a[WIDTH-1:(k+1)*CW];
        assign w_ub = g_stage[k-1].g_ops.r_b[WIDTH-1:(k+1)*CW];
      end

      // Operand bits not yet consumed, carried to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_load) begin
          r_a <= w_ua;
          r_b <= w_ub;
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_load) r_ovf <= w_cmsb ^ w_cout;
      end
    end
  end

  assign out_valid = w_vld[STAGES-1];
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 32-bit/4-stage instance driven by random traffic
// against an arithmetic scoreboard, plus an 8-bit/2-stage instance for directed
// corner cases.
module tb_pipelined_adder;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W8 = 8;
  localparam int S8 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, sum;
  logic          cin, sub, cout, ovf;

  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [W8-1:0] a8, b8, sum8;
  logic          cin8, sub8, cout8, ovf8;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(W8), .STAGES(S8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           t;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, acc_cnt = 0, emit_cnt = 0;
  bit   chk_lat = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected result from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic md, input int t);
    exp_t       e;
    longint     sx, sy, r;
    logic [W:0] f;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (md) begin
      e.s  = x - y;
      e.co = (x >= y);
      r    = sx - sy;
    end else begin
      f    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      e.s  = f[W-1:0];
      e.co = f[W];
      r    = sx + sy + longint'(c);
    end
    e.ov = (r > longint'(2147483647)) || (r < (longint'(-2147483647) - 1));
    e.t  = t;
    return e;
  endfunction

  // One clock of the 32-bit instance: sample handshakes mid-cycle, score
  // emitted beats, record accepted ones, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("out_has_expect", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.co);
        chk("ovf", ovf, e.ov);
        if (chk_lat) chk("latency", cyc - e.t, S);
      end
      emit_cnt++;
    end
    if (in_valid && in_ready) begin
      q.push_back(model(a, b, cin, sub, cyc));
      acc_cnt++;
    end
    if (rst) q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_beat();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] hold_s;
    logic         hold_c, hold_o;
    bit           have;
    int           acc0, e0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_in_ready8", in_ready8, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_in_ready8", in_ready8, 1);

    // 8-bit, 2 stages: FF + 01 wraps to 00 with carry out, two cycles later.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_not_early", out_valid8, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w8_add_valid", out_valid8, 1);
    chk("w8_add_sum", sum8, 8'h00);
    chk("w8_add_cout", cout8, 1);
    chk("w8_add_ovf", ovf8, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w8_one_cycle", out_valid8, 0);
    @(posedge clk); #1;

    // 8-bit subtract: 80-01 overflows signed, 00-01 borrows.
    sub8 = 1'b1; cin8 = 1'b1; a8 = 8'h80; b8 = 8'h01; in_valid8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h00; b8 = 8'h01;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_sub1_valid", out_valid8, 1);
    chk("w8_sub1_sum", sum8, 8'h7F);
    chk("w8_sub1_cout", cout8, 1);
    chk("w8_sub1_ovf", ovf8, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w8_sub2_valid", out_valid8, 1);
    chk("w8_sub2_sum", sum8, 8'hFF);
    chk("w8_sub2_cout", cout8, 0);
    chk("w8_sub2_ovf", ovf8, 0);
    @(posedge clk); #1;

    // Full-rate streaming: ready never drops, fixed latency.
    chk_lat = 1'b1;
    e0 = emit_cnt;
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      in_valid = 1'b1;
      chk("stream_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (S + 2) tick();
    chk("stream_count", emit_cnt - e0, 100);
    chk("stream_empty", q.size(), 0);

    // Backpressure: exactly S beats fit, outputs hold while stalled.
    chk_lat = 1'b0;
    out_ready = 1'b0;
    acc0 = acc_cnt;
    have = 1'b0;
    hold_s = '0; hold_c = 1'b0; hold_o = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
      if (out_valid) begin
        if (have) begin
          chk("frozen_sum", sum, hold_s);
          chk("frozen_cout", cout, hold_c);
          chk("frozen_ovf", ovf, hold_o);
        end else begin
          hold_s = sum; hold_c = cout; hold_o = ovf; have = 1'b1;
        end
      end
    end
    chk("bp_accepts", acc_cnt - acc0, S);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    e0 = emit_cnt;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("bp_drain", emit_cnt - e0, S);

    // Random valid/ready in both modes.
    for (int i = 0; i < 300; i++) begin
      rand_beat();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() > 0; i++) tick();
    chk("rand_drained", q.size(), 0);

    // Reset with three beats in flight discards them.
    chk_lat = 1'b1;
    repeat (S + 2) tick();
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_stale", out_valid, 0);
    end
    rand_beat();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e0 = emit_cnt;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("post_rst_beat", emit_cnt - e0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit. It generalises the 8-bit single-cycle ripple carry adder to WIDTH bits split into STAGES carry-registered chunks.
- Valid/ready handshake on input and output, full backpressure, throughput of one operation per cycle.
- Sits in the datapath library as the default wide adder where the ripple path would miss timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must satisfy WIDTH % STAGES == 0.
- STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1, cin ignored.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow (a >= b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset: all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0. in_ready=0 while rst is high, 1 in the first cycle after rst drops. Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Accept: a beat is taken when in_valid && in_ready at a rising edge. Operands and mode are not sampled otherwise.
- Stage 0 (at accept): register bits [CW-1:0] of a + b' + c0, where b' = sub ? ~b : b and c0 = sub ? 1 : cin. Also register the chunk carry, the untouched upper bits of a and b', and the stage valid.
- Stage k (1..STAGES-1): add chunk k of the carried operands plus stage k-1's registered carry. Append the result to the lower sum bits; drop the consumed operand bits.
- Last stage also registers cout and ovf. ovf needs the carry into bit WIDTH-1, taken from the MSB full-adder of the final chunk.
- Latency: result visible on sum/cout/ovf with out_valid=1 exactly STAGES cycles after the accepting edge, given no stall. STAGES=1 gives a registered single-cycle adder.
- Flow control: stage k advances when its successor is empty or advancing; the last stage advances when out_valid==0 or out_ready==1.
- in_ready = stage 0 empty or stage 0 advancing. It is combinational from out_ready through the valid chain; no bubbles are inserted.
- Stall: while out_valid && !out_ready, sum/cout/ovf/out_valid hold stable. Upstream stages fill, then in_ready drops. At most STAGES beats are in flight.
- Bubbles: empty stages collapse, so a beat never waits behind an empty slot.
- Ordering: strictly FIFO; no reordering, duplication or loss.
- Simultaneous accept and emit in the same cycle is legal and sustains 1 beat/cycle.
- Width rules: all arithmetic is modulo 2^WIDTH. cout is bit WIDTH of the full-precision a+b'+c0.

Decomposition:
- Package datapath_pkg: a localparam-style function to check WIDTH % STAGES == 0 at elaboration, and a sub-mode encoding constant ADD=1'b0, SUB=1'b1.
- Sub-module adder_chunk: combinational CW-bit ripple adder built from full-adder cells. Outputs sum[CW-1:0], carry-out, and carry into its MSB (for ovf). One instance per stage.
- The pipelined_adder top holds the stage registers and the handshake.

Test Plan:
- WIDTH=8, STAGES=2: a=8'hFF, b=8'h01, cin=0, sub=0, out_ready=1 -> exactly 2 cycles later sum=8'h00, cout=1, ovf=0, out_valid=1 for one cycle.
- WIDTH=8, STAGES=2, sub=1: a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1. Then a=8'h00, b=8'h01 -> sum=8'hFF, cout=0, ovf=0.
- Defaults: stream 100 random beats with in_valid=1 and out_ready=1 -> in_ready stays 1, one result per cycle after a 4-cycle fill, all results match the model in order.
- Defaults, backpressure: out_ready=0 for 10 cycles while feeding -> exactly 4 beats accepted, then in_ready=0, outputs frozen. Release out_ready -> 4 results drain in order, no loss.
- Random in_valid/out_ready (50% each), both modes, cin random -> scoreboard matches a+b+cin / a-b modulo 2^32, cout/ovf correct.
- Assert rst with 3 beats in flight -> next cycle out_valid=0, sum=0, cout=0, ovf=0. No stale beat ever emitted. First post-reset beat has 4-cycle latency.
